ssd1331_spi_sequencer: RTL and testbench
========================================

Name: ssd1331_spi_sequencer

Overview:
Controller that sequences the 8-bit MOSI SPI shifter for the SSD1331 OLED.
- After reset it runs the power-up sequence: RES pulse, fixed init command list, optional VCC enable, then display-on.
- It then arbitrates a single host byte stream onto the shifter using a valid/ready handshake.
- It drives the shifter's START/DATA/DC inputs, watches its final-bit flag, and owns panel CS and RES.

Parameters:
- RST_LOW_CYCLES, 16, i_SCK cycles o_RES is held low after reset release.
- RST_WAIT_CYCLES, 16, i_SCK cycles between o_RES rising and the first init byte.
- VCC_DELAY_CYCLES, 1024, i_SCK cycles between o_VCCEN rising and display-on (0xAF). Used only with VCC_SEQ_EN.
- CNT_W, 20, delay counter width. Must hold the largest delay parameter.

Ports:
- i_SCK  in  1  clock; all logic on posedge (the shifter runs on negedge of the same clock)
- i_RST_N  in  1  asynchronous, active-low reset
- i_TX_VALID  in  1  host byte valid
- i_TX_DATA  in  8  host byte
- i_TX_DC  in  1  host D/C flag (1 = data, 0 = command)
- o_TX_READY  out  1  sequencer accepts host byte this cycle
- o_INIT_DONE  out  1  power-up sequence complete; stays high until reset
- o_SPI_START  out  1  to shifter i_START; one-cycle pulse
- o_SPI_DATA  out  8  to shifter i_DATA
- o_SPI_DC  out  1  to shifter i_DC
- i_SPI_FINAL_TX  in  1  from shifter o_MOSI_FINAL_TX
- o_CS  out  1  panel chip select, active low
- o_RES  out  1  panel reset, active low
- o_VCCEN  out  1  panel VCC enable

Behaviour:
- Reset (i_RST_N=0, async): state=RST_LOW, counter=0, init index=0.
  - Outputs: o_RES=0, o_CS=1, o_SPI_START=0, o_SPI_DATA=0, o_SPI_DC=0, o_TX_READY=0, o_INIT_DONE=0, o_VCCEN=0.
  - Reset mid-transfer abandons the byte immediately. The shifter is reset by the same net.
- All outputs are registered.
- Init ROM: 20 command bytes (DC=0), in order: AE A0 72 A1 00 A2 00 A4 A8 3F AD 8E B0 0B B1 31 B3 F0 BB 3A.
- States:
  - RST_LOW: count RST_LOW_CYCLES, then o_RES<=1 and go to RST_WAIT.
  - RST_WAIT: count RST_WAIT_CYCLES, then go to LOAD.
  - LOAD: o_SPI_DATA<=current byte, o_SPI_DC<=its DC, o_SPI_START<=1 for exactly one cycle, o_CS<=0. Next state is WAIT_TX.
  - WAIT_TX: o_SPI_START=0; remain until i_SPI_FINAL_TX=1.
    - On FINAL during init: index+1. If index<19, go to LOAD; otherwise go to VCC (with macro) or DISP_ON.
    - On FINAL in host mode: go to IDLE.
  - VCC: o_VCCEN<=1, count VCC_DELAY_CYCLES, then go to DISP_ON.
  - DISP_ON: current byte=0xAF, DC=0; go through LOAD/WAIT_TX. On FINAL, set o_INIT_DONE<=1 and go to IDLE.
  - IDLE: o_TX_READY=1 and o_CS<=1.
    - Handshake fires when i_TX_VALID and o_TX_READY are both 1 on a posedge.
    - On fire: latch i_TX_DATA/i_TX_DC, drop o_TX_READY the next cycle, go to LOAD.
- o_TX_READY is 0 in every state except IDLE. Host bytes offered during init are held off, never dropped.
- Byte spacing: next o_SPI_START is no earlier than the posedge on which i_SPI_FINAL_TX is seen. The shifter therefore always samples START in its idle state, and START is never high while it shifts.
- i_SPI_FINAL_TX is ignored outside WAIT_TX.
- Counter reload: zeroed on every state entry. A delay of N means N posedges in that state. Parameter value 0 is treated as 1.
- o_CS stays low across back-to-back init bytes and rises only in IDLE.

Optional Feature:
- Macro VCC_SEQ_EN.
- Defined: VCC state present. o_VCCEN is 0 until init ROM completes, then VCC_DELAY_CYCLES of wait before 0xAF.
- Undefined: VCC state removed. o_VCCEN<=1 at the same posedge o_RES goes high, and 0xAF follows the last ROM byte directly.

Test Plan:
- Common setup: bench model is the 8-bit negedge shifter; RST_LOW_CYCLES=4, RST_WAIT_CYCLES=4, VCC_DELAY_CYCLES=8.
- Power-up, macro defined:
  - o_RES low exactly 4 cycles.
  - Captured MOSI stream equals the 20 ROM bytes then 0xAF, DC=0 for all.
  - o_VCCEN rises after byte 20, 8 cycles before 0xAF START.
  - o_INIT_DONE=1 after 0xAF FINAL.
- Host handshake: after init, send VALID with 0x5A/DC=1 and hold VALID high with 0xC3/DC=0 next.
  - Two START pulses, one per accepted byte.
  - MOSI shows 0x5A with o_DC=1, then 0xC3 with o_DC=0.
  - READY is low between the bytes.
- Early host request: VALID asserted with 0x11 from reset release → READY stays 0 until o_INIT_DONE; 0x11 is sent exactly once, after 0xAF.
- Reset mid-byte: assert i_RST_N=0 during the 3rd bit of ROM byte 5 → all outputs return to reset values immediately; after release the sequence restarts from 0xAE.
- Macro undefined: same stream without a VCC gap, and o_VCCEN=1 together with o_RES rising.

Source files
------------

// File: rtl/ssd1331_spi_sequencer.sv
// rtl/ssd1331_spi_sequencer.sv - SSD1331 power-up and host byte sequencer for an 8-bit MOSI shifter
// Optional macro VCC_SEQ_EN: adds the VCC enable dwell between the init list and display-on.
module ssd1331_spi_sequencer #(
  parameter int RST_LOW_CYCLES   = 16,
  parameter int RST_WAIT_CYCLES  = 16,
  parameter int VCC_DELAY_CYCLES = 1024,
  parameter int CNT_W            = 20
) (
  input  logic       i_SCK,
  input  logic       i_RST_N,
  input  logic       i_TX_VALID,
  input  logic [7:0] i_TX_DATA,
  input  logic       i_TX_DC,
  output logic       o_TX_READY,
  output logic       o_INIT_DONE,
  output logic       o_SPI_START,
  output logic [7:0] o_SPI_DATA,
  output logic       o_SPI_DC,
  input  logic       i_SPI_FINAL_TX,
  output logic       o_CS,
  output logic       o_RES,
  output logic       o_VCCEN
);

  // A zero delay still spends one posedge in its state.
  localparam int RST_LOW_N  = (RST_LOW_CYCLES   < 1) ? 1 : RST_LOW_CYCLES;
  localparam int RST_WAIT_N = (RST_WAIT_CYCLES  < 1) ? 1 : RST_WAIT_CYCLES;
  localparam int VCC_N      = (VCC_DELAY_CYCLES < 1) ? 1 : VCC_DELAY_CYCLES;
  localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_N - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_N - 1);
  localparam logic [CNT_W-1:0] VCC_LAST      = CNT_W'(VCC_N - 1);
  localparam logic [4:0]       ROM_LAST      = 5'd19;

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_LOAD,
    S_WAIT_TX,
    S_DISP_ON,
    S_IDLE
`ifdef VCC_SEQ_EN
    , S_VCC
`endif
  } state_t;

  typedef enum logic [1:0] {
    SRC_ROM,
    SRC_DISP,
    SRC_HOST
  } src_t;

  state_t           state;
  src_t             src;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  logic             cnt_done;
  logic [4:0]       idx;
  logic [7:0]       host_data;
  logic             host_dc;

  function automatic logic [7:0] rom_byte(input logic [4:0] i);
    case (i)
      5'd0:    rom_byte = 8'hAE;
      5'd1:    rom_byte = 8'hA0;
      5'd2:    rom_byte = 8'h72;
      5'd3:    rom_byte = 8'hA1;
      5'd4:    rom_byte = 8'h00;
      5'd5:    rom_byte = 8'hA2;
      5'd6:    rom_byte = 8'h00;
      5'd7:    rom_byte = 8'hA4;
      5'd8:    rom_byte = 8'hA8;
      5'd9:    rom_byte = 8'h3F;
      5'd10:   rom_byte = 8'hAD;
      5'd11:   rom_byte = 8'h8E;
      5'd12:   rom_byte = 8'hB0;
      5'd13:   rom_byte = 8'h0B;
      5'd14:   rom_byte = 8'hB1;
      5'd15:   rom_byte = 8'h31;
      5'd16:   rom_byte = 8'hB3;
      5'd17:   rom_byte = 8'hF0;
      5'd18:   rom_byte = 8'hBB;
      5'd19:   rom_byte = 8'h3A;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    cnt_last = VCC_LAST;
    case (state)
      S_RST_LOW:  cnt_last = RST_LOW_LAST;
      S_RST_WAIT: cnt_last = RST_WAIT_LAST;
      default:    cnt_last = VCC_LAST;
    endcase
  end

  assign cnt_done = (cnt == cnt_last);

  always_ff @(posedge i_SCK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state       <= S_RST_LOW;
      src         <= SRC_ROM;
      cnt         <= '0;
      idx         <= '0;
      host_data   <= '0;
      host_dc     <= 1'b0;
      o_TX_READY  <= 1'b0;
      o_INIT_DONE <= 1'b0;
      o_SPI_START <= 1'b0;
      o_SPI_DATA  <= '0;
      o_SPI_DC    <= 1'b0;
      o_CS        <= 1'b1;
      o_RES       <= 1'b0;
      o_VCCEN     <= 1'b0;
    end else begin
      // Counter runs only in delay states; everything else leaves it at zero for the next entry.
      cnt         <= '0;
      o_SPI_START <= 1'b0;
      case (state)
        S_RST_LOW: begin
          if (cnt_done) begin
            o_RES <= 1'b1;
`ifndef VCC_SEQ_EN
            o_VCCEN <= 1'b1;
`endif
            state <= S_RST_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RST_WAIT: begin
          if (cnt_done) begin
            src   <= SRC_ROM;
            state <= S_LOAD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_LOAD: begin
          o_SPI_START <= 1'b1;
          o_CS        <= 1'b0;
          case (src)
            SRC_ROM: begin
              o_SPI_DATA <= rom_byte(idx);
              o_SPI_DC   <= 1'b0;
            end
            SRC_DISP: begin
              o_SPI_DATA <= 8'hAF;
              o_SPI_DC   <= 1'b0;
            end
            default: begin
              o_SPI_DATA <= host_data;
              o_SPI_DC   <= host_dc;
            end
          endcase
          state <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (i_SPI_FINAL_TX) begin
            case (src)
              SRC_ROM: begin
                idx <= idx + 5'd1;
                if (idx == ROM_LAST) begin
`ifdef VCC_SEQ_EN
                  o_VCCEN <= 1'b1;
                  state   <= S_VCC;
`else
                  state   <= S_DISP_ON;
`endif
                end else begin
                  state <= S_LOAD;
                end
              end
              SRC_DISP: begin
                o_INIT_DONE <= 1'b1;
                o_TX_READY  <= 1'b1;
                o_CS        <= 1'b1;
                state       <= S_IDLE;
              end
              default: begin
                o_TX_READY <= 1'b1;
                o_CS       <= 1'b1;
                state      <= S_IDLE;
              end
            endcase
          end
        end
`ifdef VCC_SEQ_EN
        S_VCC: begin
          if (cnt_done) begin
            state <= S_DISP_ON;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        S_DISP_ON: begin
          src   <= SRC_DISP;
          state <= S_LOAD;
        end
        S_IDLE: begin
          o_CS <= 1'b1;
          if (i_TX_VALID && o_TX_READY) begin
            host_data  <= i_TX_DATA;
            host_dc    <= i_TX_DC;
            src        <= SRC_HOST;
            o_TX_READY <= 1'b0;
            state      <= S_LOAD;
          end
        end
        default: state <= S_RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1331_spi_sequencer.sv
// tb/tb_ssd1331_spi_sequencer.sv - self-checking bench with a negedge shifter model and byte scoreboard
module tb_ssd1331_spi_sequencer;

  localparam int RL = 4;
  localparam int RW = 4;
  localparam int VD = 8;
`ifdef VCC_SEQ_EN
  localparam bit VCC_ON = 1'b1;
`else
  localparam bit VCC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_dc = 1'b0;
  logic       tx_ready, init_done, spi_start, spi_dc, cs, res, vccen;
  logic [7:0] spi_data;
  logic       spi_final = 1'b0;

  always #5 clk = ~clk;

  ssd1331_spi_sequencer #(
    .RST_LOW_CYCLES  (RL),
    .RST_WAIT_CYCLES (RW),
    .VCC_DELAY_CYCLES(VD),
    .CNT_W           (20)
  ) dut (
    .i_SCK         (clk),
    .i_RST_N       (rst_n),
    .i_TX_VALID    (tx_valid),
    .i_TX_DATA     (tx_data),
    .i_TX_DC       (tx_dc),
    .o_TX_READY    (tx_ready),
    .o_INIT_DONE   (init_done),
    .o_SPI_START   (spi_start),
    .o_SPI_DATA    (spi_data),
    .o_SPI_DC      (spi_dc),
    .i_SPI_FINAL_TX(spi_final),
    .o_CS          (cs),
    .o_RES         (res),
    .o_VCCEN       (vccen)
  );

  // Shifter model: MSB first, one bit per negedge, final flag during the last bit.
  logic       busy = 1'b0;
  logic       mosi = 1'b0;
  logic       dcl = 1'b0;
  logic [7:0] sh = 8'h00;
  logic [7:0] rx = 8'h00;
  logic [2:0] b = 3'd0;
  logic [8:0] cap_q[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      spi_final <= 1'b0;
      b         <= 3'd0;
      mosi      <= 1'b0;
    end else if (!busy) begin
      spi_final <= 1'b0;
      if (spi_start) begin
        busy <= 1'b1;
        b    <= 3'd0;
        sh   <= spi_data;
        mosi <= spi_data[7];
        dcl  <= spi_dc;
      end
    end else if (b == 3'd7) begin
      busy      <= 1'b0;
      spi_final <= 1'b0;
      cap_q.push_back({dcl, rx});
    end else begin
      b         <= b + 3'd1;
      mosi      <= sh[3'd6 - b];
      spi_final <= (b == 3'd6);
    end
  end

  always @(posedge clk) if (busy) rx <= {rx[6:0], mosi};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log and protocol monitors, sampled on the negedge away from the DUT's active edge.
  int   start_cyc[$];
  int   final_cyc[$];
  int   res_cyc = -1, vccen_cyc = -1, done_cyc = -1;
  int   viol_busy_start = 0, viol_width = 0, viol_cs = 0, viol_ready_early = 0, viol_ready_busy = 0;
  logic prev_start = 1'b0;
  bit   start_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      start_seen = 1'b0;
    end else begin
      if (busy && spi_start) viol_busy_start++;
      if (spi_start && prev_start) viol_width++;
      if (spi_start && !prev_start) start_cyc.push_back(cyc);
      if (spi_final) final_cyc.push_back(cyc);
      if (res && res_cyc < 0) res_cyc = cyc;
      if (vccen && vccen_cyc < 0) vccen_cyc = cyc;
      if (init_done && done_cyc < 0) done_cyc = cyc;
      if (tx_ready && !init_done) viol_ready_early++;
      if (tx_ready && busy && b != 3'd7) viol_ready_busy++;
      if (spi_start) start_seen = 1'b1;
      if (start_seen && !init_done && cs) viol_cs++;
      prev_start = spi_start;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_res"}, res, 1'b0);
    chk({tag, "_cs"}, cs, 1'b1);
    chk({tag, "_start"}, spi_start, 1'b0);
    chk({tag, "_data"}, spi_data, 8'h00);
    chk({tag, "_dc"}, spi_dc, 1'b0);
    chk({tag, "_ready"}, tx_ready, 1'b0);
    chk({tag, "_done"}, init_done, 1'b0);
    chk({tag, "_vccen"}, vccen, 1'b0);
  endtask

  task automatic wait_ready_and_fire();
    int n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_seen", tx_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rom [20] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
                           8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'hBB, 8'h3A};
  logic [8:0] exp_q[$];

  initial begin
    int n;
    int base;
    logic [8:0] got;
    logic [7:0] d;
    logic       dc;

    // Host byte offered from before reset release must wait for init completion.
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    tx_dc    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, rom[i]});
    exp_q.push_back({1'b0, 8'hAF});
    exp_q.push_back({1'b1, 8'h11});

    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!res && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("res_low_cycles", n, RL);
    chk("vccen_at_res", vccen, !VCC_ON);

    wait_ready_and_fire();
    tx_valid = 1'b0;

    // Back-to-back host bytes with VALID held high across both.
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    tx_dc    = 1'b1;
    exp_q.push_back({1'b1, 8'h5A});
    wait_ready_and_fire();
    tx_data = 8'hC3;
    tx_dc   = 1'b0;
    exp_q.push_back({1'b0, 8'hC3});
    @(negedge clk);
    chk("ready_low_between", tx_ready, 1'b0);
    wait_ready_and_fire();
    tx_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d  = 8'($urandom);
      dc = 1'($urandom_range(0, 1));
      tx_valid = 1'b1;
      tx_data  = d;
      tx_dc    = dc;
      exp_q.push_back({dc, d});
      wait_ready_and_fire();
      tx_valid = 1'b0;
    end

    n = 0;
    while (cap_q.size() < exp_q.size() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk("byte_count", cap_q.size(), exp_q.size());
    chk("start_count", start_cyc.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 9'h1FF;
      chk($sformatf("byte%0d", i), got, exp_q[i]);
    end

    chk("rom_gap", start_cyc[5] - final_cyc[4], 1);
    chk("disp_on_gap", start_cyc[20] - final_cyc[19], VCC_ON ? (VD + 2) : 2);
    chk("vccen_rise", vccen_cyc, VCC_ON ? final_cyc[19] : res_cyc);
    chk("done_rise", done_cyc, final_cyc[20]);
    chk("start_while_busy", viol_busy_start, 0);
    chk("start_width", viol_width, 0);
    chk("cs_high_in_init", viol_cs, 0);
    chk("ready_before_done", viol_ready_early, 0);
    chk("ready_while_busy", viol_ready_busy, 0);

    // Reset during the third bit of the fifth init byte, then confirm restart from the top.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = cap_q.size();
    n = 0;
    while (!(cap_q.size() == base + 4 && busy && b == 3'd2) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("midbyte_reached", (n < 3000), 1'b1);
    chk("midbyte_data", sh, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midbyte");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = cap_q.size();
    n = 0;
    while (cap_q.size() <= base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    got = (cap_q.size() > base) ? cap_q[base] : 9'h1FF;
    chk("restart_first", got, {1'b0, 8'hAE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
